fifo_stream_reader: RTL and testbench

- Read-side engine for the team's synchronous FIFO (registered dout, one-cycle read latency).
- Pops words whenever the FIFO is non-empty and downstream has room, absorbs the read latency in a small output buffer, and presents a valid/ready stream.
- Marks packet boundaries with m_last every PKT_LEN words and keeps a running count of delivered words.
- Sits between the FIFO's read port and any stream consumer.

---
 rtl/fifo_stream_reader.sv | 92 +++++++++
 tb/tb_fifo_stream_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Pops a registered-output FIFO and re-presents its words as a
//            valid/ready stream with packet framing and a delivered-word count.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2,   // power of two, >= 2
  parameter int PKT_LEN    = 8,   // >= 1
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_read_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int c_ptr_w  = $clog2(BUF_DEPTH);
  localparam int c_occ_w  = $clog2(BUF_DEPTH + 1);
  localparam int c_sum_w  = c_occ_w + 1;
  localparam int c_beat_w = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(PKT_LEN - 1);
  localparam logic [c_sum_w-1:0]  c_depth     = c_sum_w'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
  logic [c_ptr_w-1:0]    r_head;
  logic [c_ptr_w-1:0]    r_tail;
  logic [c_occ_w-1:0]    r_occ;
  logic                  r_inflight;
  logic [c_beat_w-1:0]   r_beat;
  logic [CNT_WIDTH-1:0]  r_word_count;

  logic                  w_pop;
  logic                  w_capture;
  logic [c_sum_w-1:0]    w_budget;

  assign m_valid    = (r_occ != '0);
  assign w_pop      = m_valid && m_ready;
  assign w_capture  = r_inflight && !reset;

  // Occupancy after this cycle, counting the word already on its way from the FIFO.
  assign w_budget     = {1'b0, r_occ} + c_sum_w'(r_inflight) - c_sum_w'(w_pop);
  assign fifo_read_en = !fifo_empty && !reset && (w_budget < c_depth);

  assign m_data     = m_valid ? r_buf[r_head] : '0;
  assign m_last     = m_valid && (r_beat == c_last_beat);
  assign word_count = r_word_count;

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf[r_tail] <= fifo_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_occ        <= '0;
      r_inflight   <= 1'b0;
      r_beat       <= '0;
      r_word_count <= '0;
    end else begin
      r_inflight <= fifo_read_en;
      r_occ      <= w_budget[c_occ_w-1:0];
      if (r_inflight) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head       <= r_head + 1'b1;
        r_word_count <= r_word_count + 1'b1;
        r_beat       <= (r_beat == c_last_beat) ? '0 : r_beat + 1'b1;
      end
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (reset)
    r_occ <= c_occ_w'(BUF_DEPTH));

  a_no_read_when_empty: assert property (@(posedge clk)
    !(fifo_read_en && fifo_empty));

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Directed self-checking bench; a small FIFO model feeds the reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_read_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_last;
  logic [15:0]   word_count;

  logic          w4_read_en, w4_valid, w4_last;
  logic [DW-1:0] w4_data;
  logic [3:0]    w4_count;
  logic          p1_read_en, p1_valid, p1_last;
  logic [DW-1:0] p1_data;
  logic [15:0]   p1_count;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(2), .PKT_LEN(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read_en(fifo_read_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .word_count(word_count));

  fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(2), .PKT_LEN(8), .CNT_WIDTH(4)) dut_w4 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read_en(w4_read_en), .m_data(w4_data), .m_valid(w4_valid),
    .m_ready(m_ready), .m_last(w4_last), .word_count(w4_count));

  fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(2), .PKT_LEN(1), .CNT_WIDTH(16)) dut_p1 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_read_en(p1_read_en), .m_data(p1_data), .m_valid(p1_valid),
    .m_ready(m_ready), .m_last(p1_last), .word_count(p1_count));

  // FIFO model: registered dout, one-cycle read latency, popped by the main instance
  logic [DW-1:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int spurious = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_read_en) begin
      if (wr_ptr == rd_ptr) spurious <= spurious + 1;
      else begin
        fifo_dout <= mem[rd_ptr[7:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  // Transfer log
  int            cyc = 0;
  int            xfer_n = 0;
  int            p1_bad = 0;
  logic [DW-1:0] log_data [256];
  logic          log_last [256];
  logic [3:0]    log_wc4  [256];
  int            log_cyc  [256];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && m_valid && m_ready) begin
      log_data[xfer_n[7:0]] <= m_data;
      log_last[xfer_n[7:0]] <= m_last;
      log_wc4[xfer_n[7:0]]  <= w4_count;
      log_cyc[xfer_n[7:0]]  <= cyc;
      xfer_n <= xfer_n + 1;
    end
    if (!reset && p1_valid && !p1_last) p1_bad <= p1_bad + 1;
  end

  int n_total = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) mem[8'(wr_ptr + i)] = base + DW'(i);
    wr_ptr = wr_ptr + n;
  endtask

  task automatic wait_xfers(input int target, input int budget, input bit toggle);
    int k = 0;
    while (xfer_n < target && k < budget) begin
      if (toggle) m_ready = ~m_ready;
      tick();
      k++;
    end
    m_ready = 1'b1;
    check("xfer_count", 64'(xfer_n), 64'(target));
  endtask

  task automatic check_seq(input string tag, input int b, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, 64'(log_data[8'(b + i)]), 64'(base + DW'(i)));
      check({tag, "_last"}, 64'(log_last[8'(b + i)]), 64'((i % 8) == 7));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int r0;
    int unstable;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_last", 64'(m_last), 64'd0);
    check("rst_data", 64'(m_data), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    check("rst_rden", 64'(fifo_read_en), 64'd0);
    tick();
    reset = 1'b0;

    // T1: 8 words streamed with ready held high
    b = xfer_n; r0 = rd_ptr; m_ready = 1'b1;
    tick();
    push(32'hA0, 8);
    @(negedge clk);
    check("t1_rden_first", 64'(fifo_read_en), 64'd1);
    check("t1_valid_c0", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_c1", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_c2", 64'(m_valid), 64'd1);
    check("t1_head", 64'(m_data), 64'h A0);
    check("t1_p1_last", 64'(p1_last), 64'd1);
    wait_xfers(b + 8, 30, 1'b0);
    check_seq("t1", b, 32'hA0, 8);
    check("t1_back_to_back", 64'(log_cyc[8'(b + 7)] - log_cyc[8'(b)]), 64'd7);
    check("t1_count", 64'(word_count), 64'd8);
    check("t1_reads", 64'(rd_ptr - r0), 64'd8);
    repeat (3) tick();
    check("t1_drained", 64'(m_valid), 64'd0);

    // T2: 10-cycle stall, then release
    do_reset();
    b = xfer_n; r0 = rd_ptr; m_ready = 1'b0; unstable = 0;
    push(32'hA0, 8);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid && (m_data != 32'hA0 || m_last)) unstable++;
    end
    check("t2_stall_reads", 64'(rd_ptr - r0), 64'd2);
    check("t2_hold", 64'(unstable), 64'd0);
    check("t2_hold_valid", 64'(m_valid), 64'd1);
    check("t2_hold_data", 64'(m_data), 64'hA0);
    check("t2_no_xfer", 64'(xfer_n - b), 64'd0);
    m_ready = 1'b1;
    wait_xfers(b + 8, 30, 1'b0);
    check_seq("t2", b, 32'hA0, 8);
    check("t2_reads", 64'(rd_ptr - r0), 64'd8);

    // T3: 16 words with ready toggling every cycle
    do_reset();
    b = xfer_n; m_ready = 1'b1;
    push(32'hC0, 16);
    wait_xfers(b + 16, 100, 1'b1);
    check_seq("t3", b, 32'hC0, 16);
    check("t3_count", 64'(word_count), 64'd16);

    // T4: empty FIFO
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_rden", 64'(fifo_read_en), 64'd0);
      check("t4_valid", 64'(m_valid), 64'd0);
    end
    check("t4_p1_last", 64'(p1_last), 64'd0);

    // T5: reset lands while a read is in flight
    do_reset();
    b = xfer_n; r0 = rd_ptr; m_ready = 1'b1;
    push(32'hE0, 4);
    @(negedge clk);
    check("t5_rden", 64'(fifo_read_en), 64'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t5_rden_in_reset", 64'(fifo_read_en), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_valid", 64'(m_valid), 64'd0);
    check("t5_count", 64'(word_count), 64'd0);
    wait_xfers(b + 3, 30, 1'b0);
    check_seq("t5", b, 32'hE1, 3);
    check("t5_reads", 64'(rd_ptr - r0), 64'd4);
    repeat (3) tick();
    check("t5_drained", 64'(m_valid), 64'd0);
    check("t5_count_end", 64'(word_count), 64'd3);

    // T6: 4-bit counter wraps
    do_reset();
    b = xfer_n; m_ready = 1'b1;
    push(32'h100, 18);
    wait_xfers(b + 18, 60, 1'b0);
    check("t6_wc4_after15", 64'(log_wc4[8'(b + 15)]), 64'd15);
    check("t6_wc4_after16", 64'(log_wc4[8'(b + 16)]), 64'd0);
    check("t6_wc4_end", 64'(w4_count), 64'd2);
    check("t6_count", 64'(word_count), 64'd18);
    check("t6_last_data", 64'(log_data[8'(b + 17)]), 64'h111);

    check("spurious_reads", 64'(spurious), 64'd0);
    check("pkt1_last", 64'(p1_bad), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
